cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer for the 4-bit RISC core.
//  - Fetches an 8-bit instruction, decodes opcode ir[7:6], then strobes the
//    datapath control lines (reg_write, mem_read, mem_write, alu_op) only in the correct phase.
//  - Owns the PC and the data-memory req/ack handshake.
//  - Sits between instruction ROM, register file, ALU and data memory.
// PARAMETERS
//  PC_W         4   PC width; instruction space is 2**PC_W words
//  MEM_TIMEOUT  15  max MEM-state cycles without dmem_ack before abort; legal range >=1
// PORTS
//  clk          in   1     core clock, rising edge
//  reset        in   1     asynchronous, active-high
//  run          in   1     1 = execute instructions; 0 = park in IDLE after current instruction
//  instr        in   8     ROM data at address pc, valid in FETCH
//  dmem_ack     in   1     data memory completed request this cycle
//  pc           out  PC_W  program counter
//  ir           out  8     latched instruction
//  reg_write    out  1     register file write strobe
//  mem_read     out  1     data memory read (LOAD)
//  mem_write    out  1     data memory write (STORE)
//  alu_op       out  2     ALU select; 00 ADD, 01 SUB
//  dmem_req     out  1     data memory request, held until ack
//  busy         out  1     1 in any state except IDLE
//  instr_done   out  1     one-cycle pulse per retired instruction
//  err          out  1     sticky memory-timeout flag
// BEHAVIOUR
//  Reset values:
//  - State IDLE; pc=0, ir=0, err=0.
//  - All strobes 0; alu_op=00; busy=0.
//  Output timing:
//  - Strobes are Moore decodes of state and ir; every output is driven in every state (no latches).
//  - Default for every output is 0 / 00.
//  States:
//  - IDLE: run=1 -> FETCH.
//  - FETCH: ir<=instr; pc<=pc+1, wrapping modulo 2**PC_W -> DECODE.
//  - DECODE: ir[7:6] 00/01 -> EXEC; 10/11 -> MEM.
//  - EXEC: alu_op=ir[7:6] -> WB.
//  - MEM:
//    - dmem_req=1; mem_read=1 (LOAD) or mem_write=1 (STORE); timeout counter increments each cycle.
//    - On dmem_ack: LOAD -> WB. STORE: instr_done=1 in the ack cycle, then -> FETCH if run else IDLE.
//    - No ack for MEM_TIMEOUT cycles: err<=1, go to IDLE, no register write, no instr_done.
//  - WB: reg_write=1 and instr_done=1 for exactly one cycle -> FETCH if run else IDLE.
//  Latency:
//  - ADD/SUB: 4 cycles.
//  - LOAD: 3 cycles + N MEM cycles; STORE: 2 cycles + N MEM cycles (N>=1, N counts the ack cycle).
//  Boundary conditions:
//  - run sampled only at IDLE and at retirement; dropping run mid-instruction finishes the
//    instruction, then parks in IDLE with pc pointing at the next instruction.
//  - dmem_ack outside MEM is ignored.
//  - dmem_ack in the same cycle the timeout count is reached: the ack wins.
//  - err does not block further execution; it clears only on reset.
//  - reset mid-operation: outputs return to reset values asynchronously (dmem_req drops at once);
//    any in-flight instruction is discarded.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN:
//  - Defined: adds input port step (1 bit).
//    - IDLE -> FETCH requires run=1 and step=1 in the same cycle.
//    - After every retirement, or after a timeout, the sequencer returns to IDLE regardless of run.
//    - Result: exactly one instruction per step pulse.
//  - Undefined: no step port; run alone controls execution as described above.
// TESTING
//  1. run=1, ROM[0]=8'h05 (ADD) -> FETCH,DECODE,EXEC(alu_op=00),WB; reg_write=1 and instr_done=1 in cycle 4 only; pc=1.
//  2. ROM[0]=8'h80 (LOAD), dmem_ack on 3rd MEM cycle -> dmem_req&mem_read high 3 cycles, then one WB cycle with reg_write=1.
//  3. ROM[0]=8'hC0 (STORE), no ack, MEM_TIMEOUT=4 -> 4 MEM cycles, err=1, IDLE, no instr_done, no reg_write.
//  4. 17 ADDs with PC_W=4 and run held -> pc runs 0..15, wraps to 0, 17th fetch reads ROM[0].
//  5. Assert reset while dmem_req=1 -> dmem_req, busy and pc go to 0 before the next clk edge; after release, IDLE.
//  6. Drop run during EXEC -> WB completes, IDLE reached, pc holds; with SEQ_SINGLE_STEP_EN, one step pulse -> exactly one instr_done.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-bit RISC core; owns the PC and data-memory handshake.
// Optional single-step mode is enabled by defining SEQ_SINGLE_STEP_EN (adds the step input).
module cpu_sequencer #(
   parameter int PC_W        = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic            step,
`endif
   input  logic [7:0]      instr,
   input  logic            dmem_ack,
   output logic [PC_W-1:0] pc,
   output logic [7:0]      ir,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic [1:0]      alu_op,
   output logic            dmem_req,
   output logic            busy,
   output logic            instr_done,
   output logic            err
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             start;
   logic             resume;

   // In single-step mode every instruction parks in IDLE; start needs a step pulse.
`ifdef SEQ_SINGLE_STEP_EN
   assign start  = run & step;
   assign resume = 1'b0;
`else
   assign start  = run;
   assign resume = run;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         pc      <= '0;
         ir      <= '0;
         err     <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state <= S_FETCH;
            end
            S_FETCH: begin
               ir    <= instr;
               pc    <= pc + 1'b1;
               state <= S_DECODE;
            end
            S_DECODE: begin
               tmo_cnt <= '0;
               state   <= ir[7] ? S_MEM : S_EXEC;
            end
            S_EXEC: begin
               state <= S_WB;
            end
            S_MEM: begin
               // An ack arriving on the final allowed cycle still completes the access.
               if (dmem_ack) begin
                  if (ir[6]) state <= resume ? S_FETCH : S_IDLE;
                  else       state <= S_WB;
               end else if (tmo_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_WB: begin
               state <= resume ? S_FETCH : S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_op     = 2'b00;
      dmem_req   = 1'b0;
      instr_done = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_EXEC: alu_op = ir[7:6];
         S_MEM: begin
            dmem_req   = 1'b1;
            mem_read   = ~ir[6];
            mem_write  = ir[6];
            instr_done = ir[6] & dmem_ack;
         end
         S_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (PC_W=4, MEM_TIMEOUT=4).
module tb_cpu_sequencer;

   logic       clk;
   logic       reset;
   logic       run;
   logic       step;
   logic [7:0] instr;
   logic       dmem_ack;
   logic [3:0] pc;
   logic [7:0] ir;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic [1:0] alu_op;
   logic       dmem_req;
   logic       busy;
   logic       instr_done;
   logic       err;

   logic [7:0] rom [16];
   int         checks   = 0;
   int         failures = 0;

   assign instr = rom[pc];

   cpu_sequencer #(.PC_W(4), .MEM_TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
`ifdef SEQ_SINGLE_STEP_EN
      .step       (step),
`endif
      .instr      (instr),
      .dmem_ack   (dmem_ack),
      .pc         (pc),
      .ir         (ir),
      .reg_write  (reg_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .alu_op     (alu_op),
      .dmem_req   (dmem_req),
      .busy       (busy),
      .instr_done (instr_done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset    = 1'b1;
      run      = 1'b0;
      step     = 1'b0;
      dmem_ack = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 8'h05;

      tick();
      tick();
      chk("rst_pc",       32'(pc),         32'd0);
      chk("rst_ir",       32'(ir),         32'd0);
      chk("rst_busy",     32'(busy),       32'd0);
      chk("rst_err",      32'(err),        32'd0);
      chk("rst_dmem_req", 32'(dmem_req),   32'd0);
      chk("rst_reg_wr",   32'(reg_write),  32'd0);
      chk("rst_done",     32'(instr_done), 32'd0);
      chk("rst_alu_op",   32'(alu_op),     32'd0);
      reset = 1'b0;
      tick();
      chk("idle_no_run",  32'(busy),       32'd0);

      // ADD, run dropped during EXEC
      rom[0] = 8'h05;
      run = 1'b1;
      tick();
      chk("add_fetch_busy", 32'(busy),       32'd1);
      chk("add_fetch_done", 32'(instr_done), 32'd0);
      chk("add_fetch_pc",   32'(pc),         32'd0);
      tick();
      chk("add_dec_pc",     32'(pc),         32'd1);
      chk("add_dec_ir",     32'(ir),         32'h05);
      chk("add_dec_done",   32'(instr_done), 32'd0);
      tick();
      chk("add_exec_alu",   32'(alu_op),     32'd0);
      chk("add_exec_rw",    32'(reg_write),  32'd0);
      run = 1'b0;
      tick();
      chk("add_wb_rw",      32'(reg_write),  32'd1);
      chk("add_wb_done",    32'(instr_done), 32'd1);
      tick();
      chk("add_idle_busy",  32'(busy),       32'd0);
      chk("add_idle_done",  32'(instr_done), 32'd0);
      chk("add_idle_pc",    32'(pc),         32'd1);
      tick();
      chk("add_hold_pc",    32'(pc),         32'd1);
      chk("add_hold_busy",  32'(busy),       32'd0);

      // LOAD, ack outside MEM ignored, ack on 3rd MEM cycle
      rom[1] = 8'h80;
      run = 1'b1;
      tick();
      tick();
      chk("ld_dec_pc",   32'(pc),       32'd2);
      chk("ld_dec_ir",   32'(ir),       32'h80);
      chk("ld_dec_req",  32'(dmem_req), 32'd0);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      #1;
      chk("ld_m1_req",   32'(dmem_req),  32'd1);
      chk("ld_m1_rd",    32'(mem_read),  32'd1);
      chk("ld_m1_wr",    32'(mem_write), 32'd0);
      tick();
      chk("ld_m2_req",   32'(dmem_req),  32'd1);
      tick();
      dmem_ack = 1'b1;
      #1;
      chk("ld_m3_req",   32'(dmem_req),   32'd1);
      chk("ld_m3_rd",    32'(mem_read),   32'd1);
      chk("ld_m3_done",  32'(instr_done), 32'd0);
      tick();
      dmem_ack = 1'b0;
      #1;
      chk("ld_wb_rw",    32'(reg_write),  32'd1);
      chk("ld_wb_done",  32'(instr_done), 32'd1);
      chk("ld_wb_req",   32'(dmem_req),   32'd0);
      run = 1'b0;
      tick();
      chk("ld_idle_busy", 32'(busy), 32'd0);
      chk("ld_idle_pc",   32'(pc),   32'd2);

      // STORE with no ack: timeout after 4 MEM cycles
      rom[2] = 8'hC0;
      run = 1'b1;
      tick();
      tick();
      chk("st_dec_pc", 32'(pc), 32'd3);
      tick();
      chk("st_m1_wr",  32'(mem_write), 32'd1);
      chk("st_m1_rd",  32'(mem_read),  32'd0);
      chk("st_m1_req", 32'(dmem_req),  32'd1);
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk("st_mn_req",  32'(dmem_req),   32'd1);
         chk("st_mn_done", 32'(instr_done), 32'd0);
         chk("st_mn_err",  32'(err),        32'd0);
      end
      tick();
      run = 1'b0;
      chk("to_busy", 32'(busy),      32'd0);
      chk("to_err",  32'(err),       32'd1);
      chk("to_req",  32'(dmem_req),  32'd0);
      chk("to_rw",   32'(reg_write), 32'd0);
      tick();
      chk("to_stay_idle", 32'(busy), 32'd0);

      // STORE acked on first MEM cycle, then SUB; err stays set
      rom[3] = 8'hC5;
      rom[4] = 8'h45;
      run = 1'b1;
      tick();
      tick();
      chk("st2_dec_pc", 32'(pc), 32'd4);
      tick();
      dmem_ack = 1'b1;
      #1;
      chk("st2_ack_done", 32'(instr_done), 32'd1);
      chk("st2_ack_wr",   32'(mem_write),  32'd1);
      chk("st2_ack_rw",   32'(reg_write),  32'd0);
      tick();
      dmem_ack = 1'b0;
      #1;
      chk("sub_fetch_busy", 32'(busy),       32'd1);
      chk("sub_fetch_done", 32'(instr_done), 32'd0);
      chk("err_sticky",     32'(err),        32'd1);
      tick();
      chk("sub_dec_pc", 32'(pc), 32'd5);
      chk("sub_dec_ir", 32'(ir), 32'h45);
      tick();
      chk("sub_exec_alu", 32'(alu_op), 32'd1);
      run = 1'b0;
      tick();
      chk("sub_wb_done", 32'(instr_done), 32'd1);
      tick();
      chk("sub_idle_pc", 32'(pc),   32'd5);
      chk("sub_idle_busy", 32'(busy), 32'd0);

      // LOAD acked on the 4th MEM cycle: ack beats timeout
      rom[5] = 8'h80;
      run = 1'b1;
      tick();
      tick();
      tick();
      tick();
      tick();
      tick();
      dmem_ack = 1'b1;
      #1;
      chk("race_m4_req", 32'(dmem_req), 32'd1);
      tick();
      dmem_ack = 1'b0;
      #1;
      chk("race_wb_rw",   32'(reg_write),  32'd1);
      chk("race_wb_done", 32'(instr_done), 32'd1);
      run = 1'b0;
      tick();
      chk("race_idle_pc", 32'(pc), 32'd6);

      // Asynchronous reset while dmem_req is high
      rom[6] = 8'h80;
      run = 1'b1;
      tick();
      tick();
      tick();
      chk("ar_pre_req", 32'(dmem_req), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_req",  32'(dmem_req), 32'd0);
      chk("ar_busy", 32'(busy),     32'd0);
      chk("ar_pc",   32'(pc),       32'd0);
      chk("ar_err",  32'(err),      32'd0);
      chk("ar_ir",   32'(ir),       32'd0);
      chk("ar_rd",   32'(mem_read), 32'd0);
      run = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk("ar_idle_busy", 32'(busy), 32'd0);
      chk("ar_idle_pc",   32'(pc),   32'd0);

      // 17 back-to-back ADDs: pc wraps, 17th fetch reads ROM[0]
      for (int i = 0; i < 16; i++) rom[i] = 8'(8'h10 + i);
      run = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         chk("wrap_fetch_busy", 32'(busy), 32'd1);
         tick();
         chk("wrap_pc", 32'(pc), 32'((k + 1) % 16));
         chk("wrap_ir", 32'(ir), 32'(8'h10 + (k % 16)));
         tick();
         tick();
         chk("wrap_done", 32'(instr_done), 32'd1);
         if (k == 16) run = 1'b0;
      end
      tick();
      chk("wrap_idle_busy", 32'(busy), 32'd0);
      chk("wrap_idle_pc",   32'(pc),   32'd1);

`ifdef SEQ_SINGLE_STEP_EN
      // One step pulse runs exactly one instruction even with run held
      run  = 1'b1;
      step = 1'b0;
      tick();
      chk("ss_wait_busy", 32'(busy), 32'd0);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("ss_fetch_busy", 32'(busy), 32'd1);
      tick();
      tick();
      tick();
      chk("ss_wb_done", 32'(instr_done), 32'd1);
      tick();
      chk("ss_park_busy", 32'(busy), 32'd0);
      tick();
      chk("ss_stay_busy", 32'(busy), 32'd0);
      run = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
